// File: rtl/pattern_stream_counter_if.sv
// Parallel word handshake into the pattern stream counter.
// A word moves on a rising edge where in_valid && in_ready; in_valid may drop without a transfer and in_data matters only while in_valid is high.
interface pattern_stream_counter_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/pattern_stream_counter.sv
// Serialises parallel words one bit per clock, matches the bit stream against a
// programmable pattern (overlapping or not) and counts matches with saturation.
module pattern_stream_counter #(
    parameter int DATA_W    = 4,
    parameter int PAT_W     = 4,
    parameter int CNT_W     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    pattern_stream_counter_if.slave  in_if,
    input  logic [PAT_W-1:0]         pattern_i,
    input  logic                     overlap_i,
    input  logic                     clear_i,
    output logic                     match_o,
    output logic [CNT_W-1:0]         count_o,
    output logic                     sat_o
);

    localparam int REM_W  = $clog2(DATA_W + 1);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [REM_W-1:0]  REM_FULL  = REM_W'(DATA_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [DATA_W-1:0] word_q, word_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              match_q, match_d;
    logic              sat_q, sat_d;

    logic              accept;
    logic              shift_en;
    logic              stream_bit;
    logic              hit;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;

    // Ready while at most the last bit is left, so the next load overlaps that final shift.
    assign in_if.in_ready = (rem_q <= REM_W'(1));
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign shift_en       = (rem_q != '0);
    assign stream_bit     = MSB_FIRST ? word_q[DATA_W-1] : word_q[0];
    assign hist_next      = PAT_W'({hist_q, stream_bit});
    assign fill_next      = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    assign hit            = shift_en && (fill_next == FILL_FULL) && (hist_next == pattern_i);

    always_comb begin
        word_d  = word_q;
        rem_d   = rem_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        sat_d   = sat_q;
        match_d = hit;

        if (shift_en) begin
            word_d = MSB_FIRST ? (word_q << 1) : (word_q >> 1);
            rem_d  = rem_q - REM_W'(1);
            hist_d = hist_next;
            fill_d = (hit && !overlap_i) ? '0 : fill_next;
        end

        if (accept) begin
            word_d = in_if.in_data;
            rem_d  = REM_FULL;
        end

        // Clear beats a coincident match; the match pulse itself is unaffected.
        if (clear_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (hit && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
            if (count_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            rem_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            match_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            rem_q   <= rem_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            match_q <= match_d;
            sat_q   <= sat_d;
        end
    end

    assign match_o = match_q;
    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_pattern_stream_counter.sv
// Bench for pattern_stream_counter: two instances (MSB-first/4-bit count and
// LSB-first/16-bit count) share one stimulus stream and one stream-level model.
module tb_pattern_stream_counter;

    localparam int DATA_W = 4;
    localparam int PAT_W  = 4;
    localparam int W      = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              clear;
    logic              match_a, match_b;
    logic [3:0]        count_a;
    logic [15:0]       count_b;
    logic              sat_a, sat_b;

    pattern_stream_counter_if #(.DATA_W(DATA_W)) if_a ();
    pattern_stream_counter_if #(.DATA_W(DATA_W)) if_b ();

    pattern_stream_counter #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_if(if_a), .pattern_i(pattern), .overlap_i(overlap),
        .clear_i(clear), .match_o(match_a), .count_o(count_a), .sat_o(sat_a)
    );

    pattern_stream_counter #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(16), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_if(if_b), .pattern_i(pattern), .overlap_i(overlap),
        .clear_i(clear), .match_o(match_b), .count_o(count_b), .sat_o(sat_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pend_q holds bits still to be streamed, one entry per
    // bit as {lsb_first_bit, msb_first_bit}; index 0 is dut_a, index 1 is dut_b.
    logic [1:0]   pend_q[$];
    int unsigned  win[2];
    int           fresh[2];
    int           cnt[2];
    bit           msat[2];
    int           cnt_max[2] = '{15, 65535};
    bit           model_valid = 1'b0;
    int           model_edge = 0;
    int           mon_edge = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    // One call covers exactly one rising edge: inputs applied at the falling edge.
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit clr, input bit r);
        bit         ready_m;
        bit         hitv[2];
        logic [1:0] b2;
        if_a.in_valid = v;
        if_a.in_data  = d;
        if_b.in_valid = v;
        if_b.in_data  = d;
        clear = clr;
        rst   = r;
        ready_m = (pend_q.size() <= 1);
        if (model_valid) begin
            check("ready_a", if_a.in_ready, ready_m);
            check("ready_b", if_b.in_ready, ready_m);
            check("count_a", count_a, cnt[0]);
            check("sat_a", sat_a, msat[0]);
            check("count_b", count_b, cnt[1]);
            check("sat_b", sat_b, msat[1]);
        end
        model_edge++;
        hitv[0] = 1'b0;
        hitv[1] = 1'b0;
        if (r) begin
            pend_q.delete();
            for (int i = 0; i < 2; i++) begin
                win[i] = 0; fresh[i] = 0; cnt[i] = 0; msat[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            if (pend_q.size() > 0) begin
                b2 = pend_q.pop_front();
                for (int i = 0; i < 2; i++) begin
                    win[i] = ((win[i] << 1) | int'(b2[i])) & ((1 << PAT_W) - 1);
                    if (fresh[i] < PAT_W) fresh[i]++;
                    hitv[i] = (fresh[i] == PAT_W) && (win[i] == int'(pattern));
                    if (hitv[i] && !overlap) fresh[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (clr) begin
                    cnt[i] = 0;
                    msat[i] = 1'b0;
                end else if (hitv[i] && cnt[i] < cnt_max[i]) begin
                    cnt[i]++;
                    if (cnt[i] == cnt_max[i]) msat[i] = 1'b1;
                end
            end
            if (hitv[0]) exp_q.push_back({16'(model_edge), 16'(cnt[0]), msat[0]});
            if (hitv[1]) exp_b_q.push_back({16'(model_edge), 16'(cnt[1]), msat[1]});
            if (v && ready_m) begin
                for (int k = 0; k < DATA_W; k++) pend_q.push_back({d[k], d[DATA_W-1-k]});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 16) begin
            acc = (pend_q.size() <= 1);
            step(1'b1, d, 1'b0, 1'b0);
            n++;
        end
        if (!acc) fail_now("send_word_timeout");
    endtask

    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            mon_edge++;
            if (match_a === 1'b1) begin
                if (exp_q.size() == 0) fail_now("match_a_unexpected");
                else begin
                    e = exp_q.pop_front();
                    check("match_a_edge", mon_edge, e[32:17]);
                    check("match_a_count", count_a, e[16:1]);
                    check("match_a_sat", sat_a, e[0]);
                end
            end
            if (match_b === 1'b1) begin
                if (exp_b_q.size() == 0) fail_now("match_b_unexpected");
                else begin
                    e = exp_b_q.pop_front();
                    check("match_b_edge", mon_edge, e[32:17]);
                    check("match_b_count", count_b, e[16:1]);
                    check("match_b_sat", sat_b, e[0]);
                end
            end
        end
    end

    initial begin
        pattern = 4'b1011;
        overlap = 1'b1;
        // Reset held two cycles with a word on offer.
        step(1'b1, 4'hA, 1'b0, 1'b1);
        step(1'b1, 4'h5, 1'b0, 1'b1);
        idle(2);
        // Single match on the MSB-first instance only.
        send_word(4'hB);
        idle(6);
        // Clear lands on the edge the match completes.
        send_word(4'hB);
        idle(3);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        // Back-to-back all-ones words, overlapping then non-overlapping.
        pattern = 4'hF;
        step(1'b0, '0, 1'b1, 1'b0);
        send_word(4'hF);
        send_word(4'hF);
        idle(6);
        overlap = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        send_word(4'hF);
        send_word(4'hF);
        idle(6);
        // Saturation of the 4-bit counter, then clear.
        overlap = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) send_word(4'hF);
        idle(6);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);
        // Reset two bits into a word, then a fresh non-matching word.
        pattern = 4'b1011;
        step(1'b0, '0, 1'b1, 1'b0);
        send_word(4'hB);
        idle(2);
        step(1'b0, '0, 1'b0, 1'b1);
        send_word(4'h3);
        idle(6);
        // Random traffic with occasional pattern/mode changes, clears and resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) pattern = 4'($urandom);
            if ($urandom_range(0, 29) == 0) overlap = 1'($urandom_range(0, 1));
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 99) == 0,
                 $urandom_range(0, 399) == 0);
        end
        idle(8);
        check("exp_q_drained_a", exp_q.size(), 0);
        check("exp_q_drained_b", exp_b_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_stream_counter.md
# pattern_stream_counter

Parametrised successor to the team's fixed 4-bit serialiser / 1011-detector / 16-bit counter chain. It accepts parallel words over a valid/ready handshake and serialises them one bit per clock, MSB- or LSB-first. It then matches the bit stream against a run-time programmable pattern of configurable width, in overlapping or non-overlapping mode, and counts matches in a saturating counter. It sits between a parallel data source and status/CSR logic that reads `count`, `match` and `sat`.

## Interface
- `DATA_W`, 4: parallel input word width, ≥1.
- `PAT_W`, 4: pattern width in bits, 1..32.
- `CNT_W`, 16: match counter width, ≥2.
- `MSB_FIRST`, 1: 1 = serialise bit `DATA_W-1` first; 0 = bit 0 first.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  source has a word on `in_data`.
- `in_data`  in  DATA_W  parallel word.
- `in_ready`  out  1  block can accept a word this cycle.
- `pattern`  in  PAT_W  target pattern; bit `PAT_W-1` is the oldest bit in stream order.
- `overlap`  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
- `clear`  in  1  synchronous clear of `count` and `sat`.
- `match`  out  1  one-cycle pulse per detected match.
- `count`  out  CNT_W  number of matches, saturating.
- `sat`  out  1  sticky; set when `count` reaches all-ones.

## Operation
- **Serialiser.**
  - Holds a word register and a `remaining` counter with range 0..DATA_W.
  - Handshake: a word is accepted on an edge where `in_valid && in_ready`. At that edge `remaining` loads `DATA_W`.
  - `in_ready = (remaining <= 1)`. This makes back-to-back words gapless: the load coincides with the last bit shift of the previous word.
  - Each edge with `remaining > 0` shifts one bit into the detector and decrements `remaining`. A simultaneous load overrides the decrement.
  - `in_data` is don't-care while `in_valid=0`. `in_valid` may drop without acceptance.
- **Detector.**
  - State: a `PAT_W`-bit history shift register (newest bit at LSB) and a fill counter saturating at `PAT_W`.
  - On each shifted bit: `hist_next = {hist[PAT_W-2:0], bit}` and `fill_next = min(fill+1, PAT_W)`.
  - A match occurs when `fill_next == PAT_W` and `hist_next == pattern`.
  - `overlap=1`: history and fill are kept after a match.
  - `overlap=0`: fill is reset to 0 on a match, so the next match needs `PAT_W` fresh bits.
  - `pattern` and `overlap` are sampled every shift. Changing them mid-stream takes effect on the next shifted bit; history is not flushed.
  - No bit shifted means no match.
- **Counter.**
  - On a match: `count <= count + 1` unless `count` is all-ones.
  - `sat` is set on the edge where `count` becomes all-ones and stays set until `clear` or `rst`.
- **`clear`.**
  - Zeroes `count` and `sat` only. Serialiser and detector state are untouched.
  - If a match occurs on the same edge as `clear`, `clear` wins: `count=0`. `match` still pulses.
- **Reset.**
  - `rst` overrides everything, including `clear` and a concurrent handshake.
  - A word in flight is discarded and any partial history is lost.
  - Reset values: `in_ready=1`, `match=0`, `count=0`, `sat=0`, `remaining=0`, `hist=0`, `fill=0`.

## Timing
- Word accepted at edge E0. Its bit k (in stream order) shifts in at edge E(k+1).
- All outputs are registered:
  - `match` is high for the single cycle after the edge at which the completing bit is shifted in.
  - `count` and `sat` update on that same edge.
  - Latency from acceptance to `match`: `p+1` edges, where `p` is the stream index of the completing bit.
- Sustained throughput is one word per `DATA_W` cycles. `in_ready` is high for 1 of every `DATA_W` cycles while the source streams; it is always high when `DATA_W=1`.
- Matches span word boundaries with no penalty.
- Nothing is combinationally dependent on `in_valid` except the acceptance decision itself.

## Test plan
- **Reset:** assert `rst` for 2 cycles while `in_valid=1` → `in_ready=1`, `count=0`, `match=0`, `sat=0`, no word accepted.
- **Single match:** defaults, `pattern=4'b1011`, one word `4'hB` MSB-first → `match` pulses once, 4 cycles after acceptance; `count=1`. Same word with `MSB_FIRST=0` → no match.
- **Overlap mode:** `pattern=4'hF`, words `F` then `F` back-to-back → `overlap=1` gives `count=5`; `overlap=0` gives `count=2`. `in_ready` high exactly once in the 4 cycles between the two acceptances.
- **Saturation:** `CNT_W=4`, `pattern=4'hF`, `overlap=1`, 18 words of `F` → `count` holds 15 after the 15th match; `sat=1` from that edge; `match` keeps pulsing. `clear` for one cycle → `count=0`, `sat=0`.
- **`clear`/match collision:** assert `clear` on the edge a match completes → `count=0`, `match=1` for one cycle.
- **Reset mid-word:** accept `4'hB`, assert `rst` after 2 bits, then send `4'h3` → no match; `count` stays 0; the new word is accepted the cycle after reset.
